// File: rtl/link_pkg.sv
// Shared definitions for the board-to-board serial link.
// Used by the transmit arbiter and by the peer-side receiver so that opcodes,
// frame geometry and the FSM state encoding stay in one place.
package link_pkg;

  localparam int NUM_REQ    = 4;
  localparam int OP_W       = 2;
  localparam int PAYLOAD_W  = 12;
  localparam int FRAME_BITS = 17;
  // Opcode and payload travel together in the DATA state.
  localparam int DATA_BITS  = OP_W + PAYLOAD_W;

  localparam logic [OP_W-1:0] OP_CONNECT = 2'd0;
  localparam logic [OP_W-1:0] OP_START   = 2'd1;
  localparam logic [OP_W-1:0] OP_FINISH  = 2'd2;
  localparam logic [OP_W-1:0] OP_CELL    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } link_state_e;

  // Fixed priority, highest first: FINISH > START > CONNECT > CELL.
  // Only meaningful when at least one request bit is set.
  function automatic logic [OP_W-1:0] pick_winner(input logic [NUM_REQ-1:0] req);
    logic [OP_W-1:0] win;
    if (req[OP_FINISH])       win = OP_FINISH;
    else if (req[OP_START])   win = OP_START;
    else if (req[OP_CONNECT]) win = OP_CONNECT;
    else                      win = OP_CELL;
    return win;
  endfunction

endpackage

// File: rtl/link_bit_timer.sv
// Bit-period timer for the serial link.
// A down-counter that spans CLKS_PER_BIT cycles and pulses bit_tick in the
// last cycle of every period. Asserting load restarts a full period.
//   clk      system clock
//   reset    asynchronous, active-low
//   load     restart the period (first cycle of a new frame)
//   bit_tick one-cycle pulse in the final cycle of each bit period
module link_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  // Free-runs between frames; the wrap at zero keeps back-to-back bit
  // periods exactly CLKS_PER_BIT cycles long without another load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load || (cnt_q == '0)) begin
      cnt_q <= TOP;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bit_tick = (cnt_q == '0) && !load;

endmodule

// File: rtl/link_tx_arbiter.sv
// Transmit scheduler for the two-board link.
// Arbitrates four level requesters (CONNECT, START, FINISH, CELL) onto one
// serial wire. A 17-bit frame is sent per grant:
//   start(0), opcode[1:0] LSB first, payload[11:0] LSB first,
//   even parity (XOR of opcode and payload), stop(1),
// followed by GAP_BITS idle-high bit periods.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-low
//   req        level requests [0] CONNECT [1] START [2] FINISH [3] CELL
//   cell_data  CELL payload {value, col, row}; sampled only at grant
//   ack        one-cycle one-hot pulse naming the requester just latched
//   busy       high from grant through the end of the gap
//   tx         registered serial line, idles high
//   dbg_state  current FSM state, for observation only
// Handshake: a requester holds req until it sees its ack, and drops req in
// the cycle after the ack. A req still high when the FSM is back in IDLE is
// treated as a new request.
module link_tx_arbiter
  import link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int GAP_BITS     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PAYLOAD_W-1:0] cell_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic                 tx,
  output link_state_e          dbg_state
);

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] GAP_LAST  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  link_state_e          state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 grant;
  logic                 bit_tick;
  logic [OP_W-1:0]      win;
  logic [PAYLOAD_W-1:0] payload_sel;

  link_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (grant),
    .bit_tick(bit_tick)
  );

  assign win         = pick_winner(req);
  assign payload_sel = (win == OP_CELL) ? cell_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ack_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // tx_d is the value the line takes for the next bit, so tx stays a plain
  // register and changes exactly on bit boundaries.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    ack_d     = '0;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    grant     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        bit_idx_d = '0;
        if (req != '0) begin
          grant    = 1'b1;
          ack_d    = NUM_REQ'(1) << win;
          shift_d  = {payload_sel, win};
          parity_d = ^{payload_sel, win};
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == DATA_LAST) begin
            tx_d      = parity_q;
            bit_idx_d = '0;
            state_d   = ST_PARITY;
          end else begin
            // shift_q[0] is on the line now; bit 1 goes out next.
            tx_d      = shift_q[1];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          bit_idx_d = '0;
          if (GAP_BITS > 0) begin
            state_d = ST_GAP;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (bit_tick) begin
          if (bit_idx_q == GAP_LAST) begin
            bit_idx_d = '0;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign tx        = tx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_link_tx_arbiter.sv
// Directed bench for link_tx_arbiter with CLKS_PER_BIT=4, GAP_BITS=2.
// Expected acks and frames are queued when a request is driven and checked
// when the DUT grants and shifts the frame out.
module tb_link_tx_arbiter;
  import link_pkg::*;

  localparam int CPB         = 4;
  localparam int GAP         = 2;
  localparam int BUSY_CYCLES = FRAME_BITS * CPB + GAP * CPB;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [11:0] cell_data = 12'h000;
  logic [3:0]  ack;
  logic        busy;
  logic        tx;
  link_state_e dbg_state;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  link_tx_arbiter #(
    .CLKS_PER_BIT(CPB),
    .GAP_BITS    (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .cell_data(cell_data),
    .ack      (ack),
    .busy     (busy),
    .tx       (tx),
    .dbg_state(dbg_state)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_fail = 0;
  logic [16:0] exp_q[$];
  logic [3:0]  exp_ack_q[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic flag_fail(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s", tag);
  endtask

  // Frame bit k is transmitted k-th on the wire.
  function automatic logic [16:0] build_frame(input logic [1:0] op, input logic [11:0] pl);
    logic [16:0] f;
    f[0]     = 1'b0;
    f[2:1]   = op;
    f[14:3]  = pl;
    f[15]    = ^{pl, op};
    f[16]    = 1'b1;
    return f;
  endfunction

  function automatic int prio_pick(input logic [3:0] r);
    if (r[2])      return 2;
    else if (r[1]) return 1;
    else if (r[0]) return 0;
    else           return 3;
  endfunction

  task automatic push_expected(input int idx, input logic [11:0] data);
    exp_ack_q.push_back(4'(1 << idx));
    exp_q.push_back(build_frame(2'(idx), (idx == 3) ? data : 12'h000));
  endtask

  // Waits for a grant, checks the ack, drops that requester, then checks every
  // bit at the first cycle of its period and the busy length. Optional side
  // actions at cycle offsets from the ack cycle: raise extra requests and
  // change cell_data.
  task automatic run_frame(input string tag, input int raise_at, input logic [3:0] raise_mask,
                           input int raise_idx, input int chg_at, input logic [11:0] chg_data,
                           output int waited, output int ack_cyc);
    logic [3:0]  e_ack;
    logic [16:0] e_frame;
    int          c;
    int          extra;
    waited  = 0;
    ack_cyc = 0;
    while (ack == 4'b0 && waited < 400) begin
      tick();
      waited++;
    end
    if (ack == 4'b0) begin
      flag_fail({tag, " ack timeout"});
      return;
    end
    ack_cyc = cyc;
    if (exp_q.size() == 0) begin
      flag_fail({tag, " unexpected ack"});
      req = req & ~ack;
      return;
    end
    e_ack   = exp_ack_q.pop_front();
    e_frame = exp_q.pop_front();
    check({tag, " ack"}, 32'(ack), 32'(e_ack));
    req = req & ~ack;
    c = 0;
    extra = 0;
    while (busy === 1'b1 && c < 200) begin
      if ((c % CPB) == 0 && (c / CPB) < FRAME_BITS)
        check($sformatf("%s bit%0d", tag, c / CPB), 32'(tx), 32'(e_frame[c / CPB]));
      if (c > 0 && ack != 4'b0) extra++;
      if (c == raise_at) begin
        req = req | raise_mask;
        push_expected(raise_idx, cell_data);
      end
      if (c == chg_at) cell_data = chg_data;
      tick();
      c++;
    end
    check({tag, " busy cycles"}, 32'(c), 32'(BUSY_CYCLES));
    check({tag, " acks during frame"}, 32'(extra), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int a0, a1;
    int k;
    logic [3:0] rem;

    // Reset values
    reset = 1'b0;
    tick();
    tick();
    check("reset tx", 32'(tx), 32'(1));
    check("reset busy", 32'(busy), 32'(0));
    check("reset ack", 32'(ack), 32'(0));
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle line", 32'({tx, busy, ack}), 32'(6'b100000));
    end

    // Single CELL frame
    cell_data = 12'h935;
    req = 4'b1000;
    push_expected(3, 12'h935);
    run_frame("cell", -1, 4'b0, 0, -1, 12'h0, w, a0);
    check("cell grant latency", 32'(w), 32'(1));

    // Simultaneous requests resolved in priority order
    cell_data = 12'h7E1;
    req = 4'b1111;
    rem = 4'b1111;
    while (rem != 4'b0) begin
      k = prio_pick(rem);
      push_expected(k, cell_data);
      rem[k] = 1'b0;
    end
    run_frame("simul0", -1, 4'b0, 0, -1, 12'h0, w, a0);
    check("simul0 latency", 32'(w), 32'(1));
    for (int f = 1; f < 4; f++) begin
      run_frame($sformatf("simul%0d", f), -1, 4'b0, 0, -1, 12'h0, w, a1);
      check($sformatf("simul%0d ack spacing", f), 32'(a1 - a0), 32'(BUSY_CYCLES + 1));
      a0 = a1;
    end

    // Late request during a CELL frame
    cell_data = 12'h0F0;
    req = 4'b1000;
    push_expected(3, 12'h0F0);
    run_frame("late cell", 30, 4'b0010, 1, -1, 12'h0, w, a0);
    run_frame("late start", -1, 4'b0, 0, -1, 12'h0, w, a1);
    check("late start latency", 32'(w), 32'(1));

    // Reset in the middle of a CONNECT frame
    req = 4'b0001;
    w = 0;
    while (ack == 4'b0 && w < 400) begin
      tick();
      w++;
    end
    check("abort ack", 32'(ack), 32'(4'b0001));
    req = 4'b0000;
    repeat (7 * CPB) tick();
    check("abort pre busy", 32'(busy), 32'(1));
    check("abort pre tx", 32'(tx), 32'(0));
    #2 reset = 1'b0;
    #1;
    check("abort tx", 32'(tx), 32'(1));
    check("abort busy", 32'(busy), 32'(0));
    check("abort state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("post abort idle", 32'({tx, busy, ack}), 32'(6'b100000));
    end

    // cell_data changes after grant must not reach the wire
    cell_data = 12'hA5C;
    req = 4'b1000;
    push_expected(3, 12'hA5C);
    run_frame("isolate", -1, 4'b0, 0, 1, 12'h3C3, w, a0);

    check("leftover frames", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
